// File: rtl/uvme_obi_st_prot_chkr_pkg.sv
// Shared error bit indices and width helper
// for the OBI protocol checker.
package uvme_obi_st_prot_chkr_pkg;

  localparam int ERR_REQ_UNSTABLE = 0;
  localparam int ERR_RSP_UNEXP    = 1;
  localparam int ERR_RID_MISMATCH = 2;
  localparam int ERR_OVERFLOW     = 3;
  localparam int ERR_RSP_UNSTABLE = 4;
  localparam int ERR_TIMEOUT      = 5;
  localparam int ERR_W            = 6;

  function automatic int cnt_w(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/uvme_obi_st_prot_chkr_fifo.sv
// In-order FIFO of outstanding request IDs.
// Full push without pop and pop on empty are ignored.
module uvme_obi_st_prot_chkr_fifo
  import uvme_obi_st_prot_chkr_pkg::*;
#(
  parameter int ID_W  = 4,
  parameter int DEPTH = 4,
  parameter int CW    = cnt_w(DEPTH)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            push,
  input  logic            pop,
  input  logic [ID_W-1:0] din,
  output logic [ID_W-1:0] head,
  output logic [CW-1:0]   count,
  output logic            full,
  output logic            empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ID_W-1:0] mem_q [DEPTH];
  logic [ID_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign head  = mem_q[rptr_q];

  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      mem_d[wptr_q] = din;
      wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
    end
    if (do_pop)
      rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/uvme_obi_st_prot_chkr.sv
// Passive OBI link checker: request/response stability,
// ordering, overflow and timeout with sticky flags and stats.
module uvme_obi_st_prot_chkr
  import uvme_obi_st_prot_chkr_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int ID_W            = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int RREADY_EN       = 0,
  parameter int TIMEOUT_CYCLES  = 256,
  localparam int OW = cnt_w(MAX_OUTSTANDING)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              gnt,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ID_W-1:0]   aid,
  input  logic              rvalid,
  input  logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [ID_W-1:0]   rid,
  output logic [ERR_W-1:0]  err_o,
  output logic              err_pulse_o,
  output logic [OW-1:0]     outstanding_o,
  output logic [31:0]       n_req_o,
  output logic [31:0]       n_rsp_o
);

  localparam int  TW    = cnt_w(TIMEOUT_CYCLES);
  localparam bit  RR_EN = (RREADY_EN != 0);
  localparam bit  TO_EN = (TIMEOUT_CYCLES != 0);

  logic acc_a, acc_r, push, full, empty;
  logic [ID_W-1:0] head;

  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] sh_addr_q, sh_addr_d;
  logic              sh_we_q, sh_we_d;
  logic [DATA_W/8-1:0] sh_be_q, sh_be_d;
  logic [DATA_W-1:0] sh_wdata_q, sh_wdata_d;
  logic [ID_W-1:0]   sh_aid_q, sh_aid_d;
  logic              rpend_q, rpend_d;
  logic [ID_W-1:0]   sh_rid_q, sh_rid_d;
  logic [DATA_W-1:0] sh_rdata_q, sh_rdata_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [ERR_W-1:0]  err_q, err_d, new_err;
  logic              pulse_q, pulse_d;
  logic [31:0]       nreq_q, nreq_d, nrsp_q, nrsp_d;

  assign acc_a = req & gnt;
  assign acc_r = rvalid & (rready | ~RR_EN);
  // A full FIFO only takes a new ID when the head retires this cycle
  assign push  = acc_a & ~(full & ~acc_r);

  uvme_obi_st_prot_chkr_fifo #(
    .ID_W (ID_W),
    .DEPTH(MAX_OUTSTANDING),
    .CW   (OW)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (push),
    .pop    (acc_r),
    .din    (aid),
    .head   (head),
    .count  (outstanding_o),
    .full   (full),
    .empty  (empty)
  );

  always_comb begin
    pend_d     = req & ~gnt;
    sh_addr_d  = sh_addr_q;
    sh_we_d    = sh_we_q;
    sh_be_d    = sh_be_q;
    sh_wdata_d = sh_wdata_q;
    sh_aid_d   = sh_aid_q;
    if (pend_d & ~pend_q) begin
      sh_addr_d  = addr;
      sh_we_d    = we;
      sh_be_d    = be;
      sh_wdata_d = wdata;
      sh_aid_d   = aid;
    end
    rpend_d    = RR_EN & rvalid & ~rready;
    sh_rid_d   = rpend_d ? rid : sh_rid_q;
    sh_rdata_d = rpend_d ? rdata : sh_rdata_q;

    if (acc_r | empty | ~TO_EN)
      tcnt_d = '0;
    else if (tcnt_q != TW'(TIMEOUT_CYCLES))
      tcnt_d = tcnt_q + 1'b1;
    else
      tcnt_d = tcnt_q;

    new_err = '0;
    new_err[ERR_REQ_UNSTABLE] = pend_q & (~req | (addr != sh_addr_q) |
      (we != sh_we_q) | (be != sh_be_q) | (wdata != sh_wdata_q) |
      (aid != sh_aid_q));
    new_err[ERR_RSP_UNEXP]    = acc_r & empty;
    new_err[ERR_RID_MISMATCH] = acc_r & ~empty & (rid != head);
    new_err[ERR_OVERFLOW]     = acc_a & full & ~acc_r;
    new_err[ERR_RSP_UNSTABLE] = rpend_q & (~rvalid | (rid != sh_rid_q) |
      (rdata != sh_rdata_q));
    new_err[ERR_TIMEOUT]      = TO_EN & (tcnt_d == TW'(TIMEOUT_CYCLES));

    err_d   = err_q | new_err;
    pulse_d = |(new_err & ~err_q);
    nreq_d  = (acc_a && nreq_q != '1) ? nreq_q + 1 : nreq_q;
    nrsp_d  = (acc_r && nrsp_q != '1) ? nrsp_q + 1 : nrsp_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q     <= 1'b0;
      sh_addr_q  <= '0;
      sh_we_q    <= 1'b0;
      sh_be_q    <= '0;
      sh_wdata_q <= '0;
      sh_aid_q   <= '0;
      rpend_q    <= 1'b0;
      sh_rid_q   <= '0;
      sh_rdata_q <= '0;
      tcnt_q     <= '0;
      err_q      <= '0;
      pulse_q    <= 1'b0;
      nreq_q     <= '0;
      nrsp_q     <= '0;
    end else begin
      pend_q     <= pend_d;
      sh_addr_q  <= sh_addr_d;
      sh_we_q    <= sh_we_d;
      sh_be_q    <= sh_be_d;
      sh_wdata_q <= sh_wdata_d;
      sh_aid_q   <= sh_aid_d;
      rpend_q    <= rpend_d;
      sh_rid_q   <= sh_rid_d;
      sh_rdata_q <= sh_rdata_d;
      tcnt_q     <= tcnt_d;
      err_q      <= err_d;
      pulse_q    <= pulse_d;
      nreq_q     <= nreq_d;
      nrsp_q     <= nrsp_d;
    end
  end

  assign err_o       = err_q;
  assign err_pulse_o = pulse_q;
  assign n_req_o     = nreq_q;
  assign n_rsp_o     = nrsp_q;

endmodule

// File: tb/tb_uvme_obi_st_prot_chkr.sv
// Directed and random OBI traffic against a queue-based
// model of the protocol rules.
module tb_uvme_obi_st_prot_chkr;

  localparam int MAXO = 2;
  localparam int TO   = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req, gnt, we, rvalid, rready;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be, aid, rid;
  logic [5:0]  err_o;
  logic        err_pulse_o;
  logic [1:0]  outstanding_o;
  logic [31:0] n_req_o, n_rsp_o;

  always #5 clk = ~clk;

  uvme_obi_st_prot_chkr #(
    .ADDR_W(32), .DATA_W(32), .ID_W(4),
    .MAX_OUTSTANDING(MAXO), .RREADY_EN(1), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req(req), .gnt(gnt), .addr(addr), .we(we), .be(be),
    .wdata(wdata), .aid(aid),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid),
    .err_o(err_o), .err_pulse_o(err_pulse_o),
    .outstanding_o(outstanding_o),
    .n_req_o(n_req_o), .n_rsp_o(n_rsp_o)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model state
  int          aq[$];
  logic [5:0]  m_err;
  logic        m_pulse;
  longint      m_nreq, m_nrsp;
  int          m_t;
  bit          m_pend, m_rpend;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic        s_we;
  logic [3:0]  s_be, s_aid, s_rid;

  task automatic model_clear();
    aq.delete();
    m_err = '0; m_pulse = 0; m_nreq = 0; m_nrsp = 0; m_t = 0;
    m_pend = 0; m_rpend = 0;
  endtask

  task automatic model_step();
    bit a, r;
    int n;
    logic [5:0] ne;
    a  = req & gnt;
    r  = rvalid & rready;
    n  = aq.size();
    ne = '0;
    if (m_pend && (!req || addr != s_addr || we != s_we || be != s_be ||
        wdata != s_wdata || aid != s_aid)) ne[0] = 1;
    if (r && n == 0) ne[1] = 1;
    if (r && n > 0 && int'(rid) != aq[0]) ne[2] = 1;
    if (a && n == MAXO && !r) ne[3] = 1;
    if (m_rpend && (!rvalid || rid != s_rid || rdata != s_rdata)) ne[4] = 1;
    if (r || n == 0) m_t = 0;
    else if (m_t < TO) m_t++;
    if (m_t == TO) ne[5] = 1;
    if (r && n > 0) void'(aq.pop_front());
    if (a && !(n == MAXO && !r)) aq.push_back(int'(aid));
    m_pulse = |(ne & ~m_err);
    m_err   = m_err | ne;
    if (a && m_nreq < 64'hFFFF_FFFF) m_nreq++;
    if (r && m_nrsp < 64'hFFFF_FFFF) m_nrsp++;
    if (req && !gnt && !m_pend) begin
      s_addr = addr; s_we = we; s_be = be; s_wdata = wdata; s_aid = aid;
    end
    m_pend = req & ~gnt;
    if (rvalid && !rready) begin
      s_rid = rid; s_rdata = rdata;
    end
    m_rpend = rvalid & ~rready;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("err", 32'(err_o), 32'(m_err));
    chk("pulse", 32'(err_pulse_o), 32'(m_pulse));
    chk("outst", 32'(outstanding_o), 32'(aq.size()));
    chk("n_req", n_req_o, m_nreq[31:0]);
    chk("n_rsp", n_rsp_o, m_nrsp[31:0]);
  endtask

  task automatic drv(input logic rq, input logic gn, input logic [31:0] ad,
                     input logic [3:0] id, input logic rv, input logic rr,
                     input logic [3:0] ri, input logic [31:0] rd);
    req = rq; gnt = gn; addr = ad; aid = id;
    we = 1'b0; be = 4'hF; wdata = 32'h0;
    rvalid = rv; rready = rr; rid = ri; rdata = rd;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drv(0, 0, 0, 0, 0, 1, 0, 0);
    #2;
    chk("rst_err", 32'(err_o), 0);
    chk("rst_pulse", 32'(err_pulse_o), 0);
    chk("rst_outst", 32'(outstanding_o), 0);
    chk("rst_nreq", n_req_o, 0);
    chk("rst_nrsp", n_rsp_o, 0);
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    do_reset();

    // three in-order reads, overlapping at full depth
    drv(1, 1, 32'h10, 1, 0, 1, 0, 0); step();
    drv(1, 1, 32'h14, 2, 0, 1, 0, 0); step();
    chk("t1_full", 32'(outstanding_o), 2);
    drv(1, 1, 32'h18, 3, 1, 1, 1, 32'h11); step();
    drv(0, 0, 0, 0, 1, 1, 2, 32'h22); step();
    drv(0, 0, 0, 0, 1, 1, 3, 32'h33); step();
    drv(0, 0, 0, 0, 0, 1, 0, 0); step();
    chk("t1_err", 32'(err_o), 0);
    chk("t1_nreq", n_req_o, 3);
    chk("t1_nrsp", n_rsp_o, 3);
    chk("t1_outst", 32'(outstanding_o), 0);

    // address changes while waiting for grant
    do_reset();
    drv(1, 0, 32'h100, 0, 0, 1, 0, 0); step();
    drv(1, 0, 32'h104, 0, 0, 1, 0, 0); step();
    chk("t2_err", 32'(err_o), 32'h01);
    chk("t2_pulse", 32'(err_pulse_o), 1);
    drv(1, 1, 32'h104, 0, 0, 1, 0, 0); step();
    chk("t2_pulse_off", 32'(err_pulse_o), 0);

    // overflow beyond depth 2
    do_reset();
    drv(1, 1, 32'h0, 0, 0, 1, 0, 0); step();
    drv(1, 1, 32'h4, 1, 0, 1, 0, 0); step();
    drv(1, 1, 32'h8, 2, 0, 1, 0, 0); step();
    chk("t3_err", 32'(err_o), 32'h08);
    chk("t3_outst", 32'(outstanding_o), 2);
    do_reset();
    drv(1, 1, 32'h0, 0, 0, 1, 0, 0); step();
    drv(1, 1, 32'h4, 1, 0, 1, 0, 0); step();
    drv(1, 1, 32'h8, 2, 1, 1, 0, 0); step();
    chk("t3b_err", 32'(err_o), 0);
    chk("t3b_outst", 32'(outstanding_o), 2);

    // out-of-order response id
    do_reset();
    drv(1, 1, 32'h0, 5, 0, 1, 0, 0); step();
    drv(1, 1, 32'h4, 6, 0, 1, 0, 0); step();
    drv(0, 0, 0, 0, 1, 1, 6, 0); step();
    chk("t4_err", 32'(err_o), 32'h04);
    chk("t4_outst", 32'(outstanding_o), 1);

    // timeout after 8 cycles, then reset mid-wait
    do_reset();
    drv(1, 1, 32'h0, 3, 0, 1, 0, 0); step();
    drv(0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 7; i++) step();
    chk("t5_early", 32'(err_o[5]), 0);
    step();
    chk("t5_to", 32'(err_o[5]), 1);
    do_reset();
    drv(1, 1, 32'h0, 3, 0, 1, 0, 0); step();
    drv(0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step();
    do_reset();

    // response changes during stall, then unexpected response
    drv(1, 1, 32'h0, 0, 0, 1, 0, 0); step();
    drv(0, 0, 0, 0, 1, 0, 0, 32'hA5); step();
    drv(0, 0, 0, 0, 1, 1, 0, 32'h5A); step();
    chk("t6_err", 32'(err_o), 32'h10);
    do_reset();
    drv(0, 0, 0, 0, 1, 1, 0, 0); step();
    chk("t6b_err", 32'(err_o), 32'h02);

    // random traffic in short episodes
    for (int e = 0; e < 8; e++) begin
      do_reset();
      drv(0, 0, 0, 0, 0, 1, 0, 0);
      for (int c = 0; c < 50; c++) begin
        if (!(m_pend && $urandom_range(9) != 0)) begin
          req   = ($urandom_range(9) < 6);
          addr  = $urandom & 32'h0000_00FC;
          we    = 1'($urandom);
          be    = 4'($urandom);
          wdata = $urandom;
          aid   = 4'($urandom);
        end
        gnt = 1'($urandom);
        if (!(m_rpend && $urandom_range(7) != 0)) begin
          rvalid = (aq.size() > 0) ? ($urandom_range(2) != 0)
                                   : ($urandom_range(15) == 0);
          if (aq.size() > 0 && $urandom_range(5) != 0) rid = 4'(aq[0]);
          else rid = 4'($urandom);
          rdata = $urandom;
        end
        rready = ($urandom_range(3) != 0);
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
